// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: INCR write and read bursts into an on-chip word
// memory, with independent write and read channel state machines.
module axi_mem_responder #(
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH  = 1024
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                      s_axi_rlast,
    output logic                      o_wlast_err
);
    localparam int NB    = C_DATA_WIDTH / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int IDX_W = $clog2(C_MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

    w_state_t          r_wstate, w_wstate_next;
    r_state_t          r_rstate, w_rstate_next;
    logic              r_active;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [7:0]        r_wcnt;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [7:0]        r_rcnt;
    logic              r_wlast_err;

    logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic              w_w_final, w_r_final;
    logic              w_fetch_en;
    logic [IDX_W-1:0]  w_fetch_idx;
    logic [C_DATA_WIDTH-1:0] w_mem_rdata;
    logic              w_unused;

    // Only the word-index bits of the addresses are meaningful; the rest
    // (byte offset and bits above the memory size) are intentionally dropped.
    assign w_unused = ^{s_axi_awaddr, s_axi_araddr};

    assign w_aw_hs   = s_axi_awvalid & s_axi_awready;
    assign w_w_hs    = s_axi_wvalid  & s_axi_wready;
    assign w_b_hs    = s_axi_bvalid  & s_axi_bready;
    assign w_ar_hs   = s_axi_arvalid & s_axi_arready;
    assign w_r_hs    = s_axi_rvalid  & s_axi_rready;
    assign w_w_final = (r_wcnt == 8'd0);
    assign w_r_final = (r_rcnt == 8'd0);

    // The memory is fetched on the AR handshake (first beat) and on every
    // non-final R handshake (next beat), so the output register only moves
    // when the master has consumed the current beat.
    assign w_fetch_en  = w_ar_hs | (w_r_hs & ~w_r_final);
    assign w_fetch_idx = w_ar_hs ? s_axi_araddr[OFS_W +: IDX_W] : r_rd_idx + 1'b1;

    // Outputs are held low until the first clock edge after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_active <= 1'b0;
        else           r_active <= 1'b1;
    end

    // Write FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_wstate <= W_IDLE;
        else           r_wstate <= w_wstate_next;
    end

    // Write FSM next-state logic; beat count alone ends the burst
    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs)              w_wstate_next = W_DATA;
            W_DATA:  if (w_w_hs && w_w_final)  w_wstate_next = W_RESP;
            W_RESP:  if (w_b_hs)               w_wstate_next = W_IDLE;
            default:                           w_wstate_next = W_IDLE;
        endcase
    end

    // Write FSM outputs: each ready/valid is high only in its own state
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE:  s_axi_awready = r_active;
            W_DATA:  s_axi_wready  = 1'b1;
            W_RESP:  s_axi_bvalid  = 1'b1;
            default: ;
        endcase
    end

    // Write burst index and remaining-beat counter
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_idx <= '0;
            r_wcnt   <= '0;
        end else if (w_aw_hs) begin
            r_wr_idx <= s_axi_awaddr[OFS_W +: IDX_W];
            r_wcnt   <= s_axi_awlen;
        end else if (w_w_hs) begin
            r_wr_idx <= r_wr_idx + 1'b1;
            r_wcnt   <= r_wcnt - 1'b1;
        end
    end

    // Sticky flag: wlast disagreed with the beat count on some beat
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)                                  r_wlast_err <= 1'b0;
        else if (w_w_hs && (s_axi_wlast != w_w_final)) r_wlast_err <= 1'b1;
    end

    assign o_wlast_err = r_wlast_err;

    // Read FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_rstate <= R_IDLE;
        else           r_rstate <= w_rstate_next;
    end

    // Read FSM next-state logic
    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)              w_rstate_next = R_BURST;
            R_BURST: if (w_r_hs && w_r_final)  w_rstate_next = R_IDLE;
            default:                           w_rstate_next = R_IDLE;
        endcase
    end

    // Read FSM outputs; rdata is forced to zero whenever no beat is offered
    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        s_axi_rdata   = '0;
        case (r_rstate)
            R_IDLE:  s_axi_arready = r_active;
            R_BURST: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = w_r_final;
                s_axi_rdata  = w_mem_rdata;
            end
            default: ;
        endcase
    end

    // Read burst index of the beat on the bus and beats left after it
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rd_idx <= '0;
            r_rcnt   <= '0;
        end else if (w_fetch_en) begin
            r_rd_idx <= w_fetch_idx;
            r_rcnt   <= w_ar_hs ? s_axi_arlen : r_rcnt - 1'b1;
        end
    end

    // One memory per byte lane so byte enables map onto plain RAM writes.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] r_lane_mem [C_MEM_DEPTH];
            logic [7:0] r_lane_rd;

            // Byte write when strobed; registered read sees the old contents
            always_ff @(posedge ap_clk) begin
                if (w_w_hs && s_axi_wstrb[gi])
                    r_lane_mem[r_wr_idx] <= s_axi_wdata[gi*8 +: 8];
                if (w_fetch_en)
                    r_lane_rd <= r_lane_mem[w_fetch_idx];
            end

            assign w_mem_rdata[gi*8 +: 8] = r_lane_rd;
        end
    endgenerate

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: table of burst vectors, randomized bursts and
// directed corner sequences, all checked against a word-array memory model.
module tb_axi_mem_responder;
    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1024;
    localparam int TMO   = 2000;
    localparam int NT    = 11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [DW-1:0]   wdata, rdata;
    logic [NB-1:0]   wstrb;
    logic            arvalid, arready, rvalid, rready, rlast, wlast_err;

    logic [DW-1:0]   model_mem [DEPTH];
    bit              model_err;
    logic [DW-1:0]   wbuf_d [256];
    logic [NB-1:0]   wbuf_s [256];
    logic [DW-1:0]   rd_buf [256];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
        bit            do_write;
        int            data_mode;   // 0 random, 1 all ones, 2 all zeros
        int            strb_mode;   // 0 all bytes, 1 random, 2 byte 0 only
        int            wlast_mode;  // 0 correct, 1 wlast only on beat 2, 2 never
        int            rr_mode;     // 0 always ready, 1 random, 2 pattern 1,0,0
        bit            exp_err;
    } vec_t;

    vec_t tbl [NT];

    always #5 clk = ~clk;

    axi_mem_responder #(
        .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MEM_DEPTH(DEPTH)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_rdata(rdata), .s_axi_rlast(rlast),
        .o_wlast_err(wlast_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout after %0d cycles, required handshake", name, TMO);
    endtask

    function automatic int word_of(input logic [AW-1:0] a);
        return int'((a >> 6) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic pick_rr(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return (t % 3 == 0);
        endcase
    endfunction

    task automatic fill_wbuf(input int len, input int dmode, input int smode);
        for (int b = 0; b <= len; b++) begin
            case (dmode)
                1:       wbuf_d[b] = '1;
                2:       wbuf_d[b] = '0;
                default: wbuf_d[b] = rand_word();
            endcase
            case (smode)
                1:       wbuf_s[b] = {$urandom(), $urandom()};
                2:       wbuf_s[b] = 64'h1;
                default: wbuf_s[b] = '1;
            endcase
        end
    endtask

    // Full write burst from wbuf_d/wbuf_s; entered and left at a falling edge.
    task automatic axi_write(input logic [AW-1:0] addr, input int len, input int wl_mode);
        int idx = word_of(addr);
        int cyc;
        int wi;
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
        cyc = 0;
        while (awready !== 1'b1 && cyc < TMO) begin @(negedge clk); cyc++; end
        if (cyc >= TMO) begin timeout_fail("aw_handshake"); awvalid = 1'b0; return; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wvalid = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
            wvalid = 1'b1; wdata = wbuf_d[b]; wstrb = wbuf_s[b];
            case (wl_mode)
                1:       wlast = (b == 1);
                2:       wlast = 1'b0;
                default: wlast = (b == len);
            endcase
            cyc = 0;
            while (wready !== 1'b1 && cyc < TMO) begin @(negedge clk); cyc++; end
            if (cyc >= TMO) begin timeout_fail("w_handshake"); wvalid = 1'b0; return; end
            chk("bvalid_during_data", bvalid, 1'b0);
            chk("awready_during_data", awready, 1'b0);
            wi = (idx + b) % DEPTH;
            for (int k = 0; k < NB; k++)
                if (wbuf_s[b][k]) model_mem[wi][k*8 +: 8] = wbuf_d[b][k*8 +: 8];
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (wl_mode != 0) model_err = 1'b1;
        chk("wready_after_final", wready, 1'b0);
        chk("bvalid_after_final", bvalid, 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bready = 1'b1;
        cyc = 0;
        while (bvalid !== 1'b1 && cyc < TMO) begin @(negedge clk); cyc++; end
        if (cyc >= TMO) begin timeout_fail("b_handshake"); bready = 1'b0; return; end
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_after_b", bvalid, 1'b0);
        chk("awready_after_b", awready, 1'b1);
        chk("wlast_err_after_write", wlast_err, model_err);
        $display("WR word=%0d beats=%0d wlast_mode=%0d", idx, len + 1, wl_mode);
    endtask

    // Read burst checked beat by beat; abort_after>=0 stops after that many beats.
    task automatic axi_read(input logic [AW-1:0] addr, input int len, input int rr_mode,
                            input int abort_after);
        int idx = word_of(addr);
        int cyc;
        int b = 0;
        int t = 0;
        bit stalled = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        arvalid = 1'b1; araddr = addr; arlen = 8'(len);
        cyc = 0;
        while (arready !== 1'b1 && cyc < TMO) begin @(negedge clk); cyc++; end
        if (cyc >= TMO) begin timeout_fail("ar_handshake"); arvalid = 1'b0; return; end
        @(negedge clk);
        arvalid = 1'b0;
        while (b <= len) begin
            if (b == abort_after) begin rready = 1'b0; return; end
            if (t >= TMO) begin timeout_fail("r_burst"); rready = 1'b0; return; end
            chk("rvalid_in_burst", rvalid, 1'b1);
            if (stalled) begin
                chk("rdata_stable", rdata, prev_d);
                chk("rlast_stable", rlast, prev_l);
            end
            rready = pick_rr(rr_mode, t);
            t++;
            if (rready) begin
                chk("rdata", rdata, model_mem[(idx + b) % DEPTH]);
                chk("rlast", rlast, (b == len));
                rd_buf[b] = rdata;
                b++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev_d  = rdata;
                prev_l  = rlast;
            end
            @(negedge clk);
        end
        rready = 1'b0;
        chk("rvalid_after_burst", rvalid, 1'b0);
        chk("arready_after_burst", arready, 1'b1);
        $display("RD word=%0d beats=%0d rr_mode=%0d", idx, len + 1, rr_mode);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] old_v, new_v;

        tbl[0]  = '{64'h40,        3,   1'b1, 0, 0, 0, 0, 1'b0};
        tbl[1]  = '{64'd320,       0,   1'b1, 1, 0, 0, 0, 1'b0};
        tbl[2]  = '{64'd320,       0,   1'b1, 2, 2, 0, 0, 1'b0};
        tbl[3]  = '{64'h2000,      7,   1'b1, 0, 0, 0, 2, 1'b0};
        tbl[4]  = '{64'(1023*64),  1,   1'b1, 0, 0, 0, 0, 1'b0};
        tbl[5]  = '{64'h0,         0,   1'b0, 0, 0, 0, 0, 1'b0};
        tbl[6]  = '{64'h12345,     15,  1'b1, 0, 1, 0, 1, 1'b0};
        tbl[7]  = '{64'hFFFF_FFFF_0000_0000 + 64'(300*64) + 64'd7, 255, 1'b1, 0, 1, 0, 1, 1'b0};
        tbl[8]  = '{64'(600*64),   2,   1'b1, 0, 0, 1, 0, 1'b1};
        tbl[9]  = '{64'(700*64),   0,   1'b1, 0, 0, 0, 0, 1'b1};
        tbl[10] = '{64'(710*64),   3,   1'b1, 0, 0, 2, 1, 1'b1};

        awvalid = 0; awaddr = '0; awlen = '0; wvalid = 0; wdata = '0; wstrb = '0;
        wlast = 0; bready = 0; arvalid = 0; araddr = '0; arlen = '0; rready = 0;
        model_err = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_wlast_err", wlast_err, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("arready_before_first_edge", arready, 1'b0);
        @(negedge clk);
        chk("arready_after_first_edge", arready, 1'b1);
        chk("awready_after_first_edge", awready, 1'b1);

        // Give every word a defined value
        for (int p = 0; p < DEPTH / 256; p++) begin
            fill_wbuf(255, 0, 0);
            axi_write(64'(p * 256 * 64), 255, 0);
        end

        // Table of burst vectors
        for (int i = 0; i < NT; i++) begin
            if (tbl[i].do_write) begin
                fill_wbuf(tbl[i].len, tbl[i].data_mode, tbl[i].strb_mode);
                axi_write(tbl[i].addr, tbl[i].len, tbl[i].wlast_mode);
            end
            axi_read(tbl[i].addr, tbl[i].len, tbl[i].rr_mode, -1);
            chk("tbl_wlast_err", wlast_err, tbl[i].exp_err);
            $display("VEC %0d addr=%h len=%0d done", i, tbl[i].addr, tbl[i].len);
        end

        // Byte-strobe merge on word 5: byte 0 cleared, all others 0xFF
        axi_read(64'd320, 0, 0, -1);
        chk("word5_merge", rd_buf[0], {{63{8'hFF}}, 8'h00});

        // Randomized bursts
        for (int it = 0; it < 30; it++) begin
            int len;
            ra  = {$urandom(), $urandom()};
            len = $urandom_range(0, 15);
            fill_wbuf(len, 0, 1);
            axi_write(ra, len, 0);
            axi_read(ra, len, 1, -1);
            ra = {$urandom(), $urandom()};
            axi_read(ra, $urandom_range(0, 15), $urandom_range(0, 2), -1);
        end

        // Same-cycle write and read fetch of word 100: read sees old data
        old_v = model_mem[100];
        new_v = rand_word();
        awvalid = 1'b1; awaddr = 64'(100 * 64); awlen = 8'd0;
        for (int c = 0; c < TMO && awready !== 1'b1; c++) @(negedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        chk("coll_wready", wready, 1'b1);
        chk("coll_arready", arready, 1'b1);
        wvalid = 1'b1; wdata = new_v; wstrb = '1; wlast = 1'b1;
        arvalid = 1'b1; araddr = 64'(100 * 64); arlen = 8'd0; rready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        chk("coll_rvalid", rvalid, 1'b1);
        chk("coll_pre_write_data", rdata, old_v);
        chk("coll_rlast", rlast, 1'b1);
        chk("coll_bvalid", bvalid, 1'b1);
        model_mem[100] = new_v;
        bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        chk("coll_rvalid_after", rvalid, 1'b0);
        chk("coll_bvalid_after", bvalid, 1'b0);
        $display("COLLISION word=100 done");
        axi_read(64'(100 * 64), 0, 0, -1);

        // Reset during beat 2 of an 8-beat read
        axi_read(64'h2000, 7, 0, 1);
        chk("midrst_rvalid_before", rvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_rlast", rlast, 1'b0);
        chk("midrst_rdata", rdata, '0);
        chk("midrst_arready", arready, 1'b0);
        chk("midrst_awready", awready, 1'b0);
        chk("midrst_wready", wready, 1'b0);
        chk("midrst_bvalid", bvalid, 1'b0);
        chk("midrst_wlast_err", wlast_err, 1'b0);
        model_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_arready_before_edge", arready, 1'b0);
        @(negedge clk);
        chk("midrst_arready_after_edge", arready, 1'b1);
        chk("midrst_awready_after_edge", awready, 1'b1);
        chk("midrst_rvalid_after_edge", rvalid, 1'b0);
        $display("RESET mid-burst done");
        axi_read(64'h2000, 7, 2, -1);
        axi_read(64'h40, 3, 0, -1);
        chk("final_wlast_err", wlast_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The block SHALL have parameter C_ADDR_WIDTH, default 64: width of AXI byte address.
REQ-002 The block SHALL have parameter C_DATA_WIDTH, default 512: width of AXI data bus; must be a power of 2 and at least 32.
REQ-003 The block SHALL have parameter C_MEM_DEPTH, default 1024: number of C_DATA_WIDTH words stored; must be a power of 2.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- ap_clk  in  1  sole clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_awaddr  in  C_ADDR_WIDTH  write burst byte address.
- s_axi_awlen  in  8  write burst beats minus 1.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_wdata  in  C_DATA_WIDTH  write data.
- s_axi_wstrb  in  C_DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid  out  1  write response valid (response is always OKAY).
- s_axi_bready  in  1  write response ready.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  C_ADDR_WIDTH  read burst byte address.
- s_axi_arlen  in  8  read burst beats minus 1.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  C_DATA_WIDTH  read data.
- s_axi_rlast  out  1  last read beat.
- o_wlast_err  out  1  sticky flag: wlast disagreed with awlen.

Function
REQ-005 Word index SHALL be (addr >> log2(C_DATA_WIDTH/8)) mod C_MEM_DEPTH; low address bits are ignored; each beat increments the index with wrap-around from C_MEM_DEPTH-1 to 0 (INCR bursts only).
REQ-006 Read and write channels SHALL operate as independent concurrent state machines.
REQ-007 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1); awready, wready and bvalid SHALL each be 1 only in their own state.
REQ-008 An AW handshake in W_IDLE SHALL latch the index and the count awlen+1 and move to W_DATA.
REQ-009 Each W handshake SHALL write the bytes whose wstrb bit is 1 and leave bytes with wstrb=0 unchanged.
REQ-010 The burst SHALL end after exactly awlen+1 W handshakes, regardless of wlast.
REQ-011 On the final beat the FSM SHALL go to W_RESP, and a B handshake SHALL return it to W_IDLE.
REQ-012 o_wlast_err SHALL set when wlast=1 on a non-final beat or wlast=0 on the final beat, and SHALL clear only on reset.
REQ-013 Read FSM SHALL have states R_IDLE (arready=1) and R_BURST.
REQ-014 An AR handshake SHALL latch the index and the count arlen+1, and rvalid SHALL assert on the next cycle with rdata equal to mem[index].
REQ-015 While rvalid=1 and rready=0, rdata, rlast and rvalid SHALL hold stable.
REQ-016 Each R handshake SHALL present the next word on the following cycle with no bubble, giving sustained 1 beat/cycle when rready=1.
REQ-017 rlast SHALL be 1 only on beat arlen+1; an R handshake with rlast=1 SHALL return the FSM to R_IDLE with rvalid=0 on the next cycle.
REQ-018 When a read fetch and a write target the same word in the same cycle, the read SHALL return the pre-write value.
REQ-019 Memory contents SHALL NOT be initialised; reads of words never written return X in simulation.

Reset
REQ-020 Asserting ap_rst_n=0 SHALL immediately force both FSMs to idle, abandoning any burst in progress.
REQ-021 During reset SHALL hold: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, rdata=0, o_wlast_err=0.
REQ-022 awready and arready SHALL rise on the first clock edge after ap_rst_n deasserts.
REQ-023 Reset SHALL NOT clear memory contents.

Verification
REQ-024 Write awaddr=0x40, awlen=3 with data D0..D3 and full wstrb, then read araddr=0x40, arlen=3 (C_DATA_WIDTH=512) -> rdata D0..D3, rlast only on beat 4, bvalid exactly once.
REQ-025 Write word 5 with all-ones data, then write word 5 with zero data and wstrb=0x...0001 -> read of word 5 has byte 0 = 0x00 and all other bytes 0xFF.
REQ-026 Read arlen=7 with rready toggling 1,0,0,1,... -> no beats lost or duplicated and rdata stable across stalls.
REQ-027 Write awaddr=(C_MEM_DEPTH-1)*64, awlen=1 -> second beat lands in word 0, confirmed by readback.
REQ-028 Write awlen=2 with wlast asserted on beat 2 -> o_wlast_err=1, burst still takes 3 beats, bvalid once; flag stays set until reset.
REQ-029 Assert ap_rst_n=0 mid read burst at beat 2 of 8 -> rvalid=0 immediately, arready=1 on first edge after release, previously written data intact.
